keccak_sponge_ctrl: RTL and testbench

Sequencing FSM for the Keccak sponge datapath. It accepts message lanes on a valid/ready stream and issues byte-accurate lane-XOR strobes into the state array. It starts the permutation whenever the rate fills, drives the suffix padder (rate, bytes absorbed, suffix, commit strobe) at end of message, then squeezes output lanes. The state registers, lane XOR, padder and permutation core are external; this block only sequences them.

---
 rtl/keccak_sponge_ctrl_if.sv | 70 +++++++
 rtl/keccak_sponge_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_keccak_sponge_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_sponge_ctrl_if.sv
// -----------------------------------------------------------------------------
// keccak_sponge_ctrl_if
//   Bundles every non-clock signal of the Keccak sponge sequencer.
//   slave  : the controller's view (drives *_o, samples *_i)
//   master : the environment's view (message source, padder, permutation core,
//            squeeze consumer)
//   Groups : command (start/mode/stop), message lane stream, state-array
//            write strobes, padder controls, permutation handshake,
//            squeeze lane stream, status.
// -----------------------------------------------------------------------------
interface keccak_sponge_ctrl_if #(
  parameter int RATE_W = 11,
  parameter int BA_W   = 8
);
  // Command
  logic              start_i;
  logic [1:0]        mode_i;
  logic              stop_i;
  // Message lane stream
  logic              in_valid_i;
  logic              in_ready_o;
  logic              in_last_i;
  logic [3:0]        in_bytes_i;
  // State array write strobes
  logic              clear_state_o;
  logic              lane_wr_en_o;
  logic [4:0]        lane_idx_o;
  logic [3:0]        lane_bytes_o;
  // Padder
  logic [RATE_W-1:0] rate_o;
  logic [7:0]        suffix_o;
  logic [BA_W-1:0]   bytes_absorbed_o;
  logic              pad_en_o;
  // Permutation core
  logic              perm_start_o;
  logic              perm_done_i;
  // Squeeze lane stream
  logic              out_valid_o;
  logic              out_ready_i;
  logic [4:0]        out_lane_idx_o;
  // Status
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  start_i, mode_i, stop_i,
    input  in_valid_i, in_last_i, in_bytes_i,
    output in_ready_o,
    output clear_state_o, lane_wr_en_o, lane_idx_o, lane_bytes_o,
    output rate_o, suffix_o, bytes_absorbed_o, pad_en_o,
    output perm_start_o,
    input  perm_done_i,
    output out_valid_o, out_lane_idx_o,
    input  out_ready_i,
    output busy_o, done_o
  );

  modport master (
    output start_i, mode_i, stop_i,
    output in_valid_i, in_last_i, in_bytes_i,
    input  in_ready_o,
    input  clear_state_o, lane_wr_en_o, lane_idx_o, lane_bytes_o,
    input  rate_o, suffix_o, bytes_absorbed_o, pad_en_o,
    input  perm_start_o,
    output perm_done_i,
    input  out_valid_o, out_lane_idx_o,
    output out_ready_i,
    input  busy_o, done_o
  );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// keccak_pkg
//   Shared widths, FSM state encoding and the per-mode sponge configuration.
//
// keccak_sponge_ctrl
//   Sequencing FSM for an external Keccak sponge datapath. Absorbs message
//   lanes (issuing byte-masked lane XOR strobes), starts the permutation each
//   time the rate fills, commits the suffix padder at end of message, then
//   squeezes output lanes (fixed count for SHA3, until stop_i for SHAKE).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : keccak_sponge_ctrl_if.slave (command, lane streams,
//                  padder / permutation controls, status)
// -----------------------------------------------------------------------------
package keccak_pkg;
  localparam int LANE_BYTES        = 8;
  localparam int RATE_WIDTH        = 11;  // holds 1344
  localparam int BYTE_ABSORB_WIDTH = 8;   // holds 168 (largest rate in bytes)

  typedef enum logic [2:0] {
    ST_IDLE, ST_ABSORB, ST_PERM_ABS, ST_PAD, ST_PERM_PAD, ST_SQUEEZE, ST_PERM_SQZ
  } state_e;

  typedef struct packed {
    logic [RATE_WIDTH-1:0] rate;          // bits
    logic [4:0]            rate_lanes;    // rate / 64
    logic [4:0]            digest_lanes;  // SHA3 output length; unused for XOF
    logic [7:0]            suffix;
    logic                  xof;           // SHAKE: squeeze until stop_i
  } mode_cfg_t;

  function automatic mode_cfg_t mode_cfg(input logic [1:0] mode);
    mode_cfg_t cfg;
    case (mode)
      2'd0:    cfg = '{rate: 11'd1088, rate_lanes: 5'd17, digest_lanes: 5'd4, suffix: 8'h06, xof: 1'b0};
      2'd1:    cfg = '{rate: 11'd576,  rate_lanes: 5'd9,  digest_lanes: 5'd8, suffix: 8'h06, xof: 1'b0};
      2'd2:    cfg = '{rate: 11'd1344, rate_lanes: 5'd21, digest_lanes: 5'd0, suffix: 8'h1F, xof: 1'b1};
      default: cfg = '{rate: 11'd1088, rate_lanes: 5'd17, digest_lanes: 5'd0, suffix: 8'h1F, xof: 1'b1};
    endcase
    return cfg;
  endfunction
endpackage

module keccak_sponge_ctrl
  import keccak_pkg::*;
#(
  parameter int LANE_BYTES = keccak_pkg::LANE_BYTES,
  parameter int RATE_W     = RATE_WIDTH,
  parameter int BA_W       = BYTE_ABSORB_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  keccak_sponge_ctrl_if.slave bus
);

  state_e          state_q, state_d;
  mode_cfg_t       cfg_q, cfg_d;
  logic [BA_W-1:0] count_q, count_d;     // bytes absorbed into current block
  logic            pending_q, pending_d; // message ended exactly on a block boundary
  logic [4:0]      sq_idx_q, sq_idx_d;   // next lane to squeeze
  logic            entry_q;              // first cycle spent in state_q
  logic            done_q;

  logic [BA_W-1:0] count_sum;
  logic [BA_W-1:0] rate_bytes;
  logic [4:0]      sq_last;
  logic            stop_req;
  logic            out_fire;
  logic            in_fire;

  assign count_sum  = count_q + BA_W'(bus.in_bytes_i);
  assign rate_bytes = BA_W'(cfg_q.rate >> 3);
  assign sq_last    = cfg_q.xof ? cfg_q.rate_lanes - 5'd1 : cfg_q.digest_lanes - 5'd1;
  assign in_fire    = (state_q == ST_ABSORB) && bus.in_valid_i;
  // stop_i wins over a simultaneous squeeze handshake and only exists for XOF.
  assign stop_req   = (state_q == ST_SQUEEZE) && cfg_q.xof && bus.stop_i;
  assign out_fire   = (state_q == ST_SQUEEZE) && bus.out_ready_i && !stop_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      sq_idx_q  <= '0;
      entry_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      sq_idx_q  <= sq_idx_d;
      entry_q   <= (state_d != state_q);
      done_q    <= (state_q == ST_SQUEEZE) && (state_d == ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: hold-value defaults up front keep this block free of inferred latches.
    state_d   = state_q;
    cfg_d     = cfg_q;
    count_d   = count_q;
    pending_d = pending_q;
    sq_idx_d  = sq_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          cfg_d     = mode_cfg(bus.mode_i);
          count_d   = '0;
          pending_d = 1'b0;
          sq_idx_d  = '0;
          state_d   = ST_ABSORB;
        end
      end
      ST_ABSORB: begin
        if (in_fire) begin
          count_d = count_sum;
          if (count_sum >= rate_bytes) begin
            // A last lane that fills the block still needs a full padding block.
            pending_d = bus.in_last_i;
            state_d   = ST_PERM_ABS;
          end else if (bus.in_last_i) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PERM_ABS: begin
        if (bus.perm_done_i) begin
          count_d = '0;
          if (pending_q) begin
            pending_d = 1'b0;
            state_d   = ST_PAD;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end
      ST_PAD: state_d = ST_PERM_PAD;
      ST_PERM_PAD: begin
        if (bus.perm_done_i) begin
          sq_idx_d = '0;
          state_d  = ST_SQUEEZE;
        end
      end
      ST_SQUEEZE: begin
        if (stop_req) begin
          sq_idx_d = '0;
          state_d  = ST_IDLE;
        end else if (out_fire) begin
          if (sq_idx_q == sq_last) begin
            sq_idx_d = '0;
            state_d  = cfg_q.xof ? ST_PERM_SQZ : ST_IDLE;
          end else begin
            sq_idx_d = sq_idx_q + 5'd1;
          end
        end
      end
      ST_PERM_SQZ: begin
        if (bus.perm_done_i) begin
          sq_idx_d = '0;
          state_d  = ST_SQUEEZE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready_o       = (state_q == ST_ABSORB);
    bus.clear_state_o    = (state_q == ST_IDLE) && bus.start_i;
    bus.lane_wr_en_o     = in_fire && (bus.in_bytes_i != 4'd0);
    bus.lane_idx_o       = '0;
    bus.lane_bytes_o     = '0;
    if (bus.lane_wr_en_o) begin
      bus.lane_idx_o   = 5'(count_q / BA_W'(LANE_BYTES));
      bus.lane_bytes_o = bus.in_bytes_i;
    end
    bus.rate_o           = RATE_W'(cfg_q.rate);
    bus.suffix_o         = cfg_q.suffix;
    bus.bytes_absorbed_o = count_q;
    bus.pad_en_o         = (state_q == ST_PAD);
    // Every PERM_* state is entered from a non-PERM state, so the entry pulse
    // can never land on two consecutive cycles.
    bus.perm_start_o     = entry_q &&
                           (state_q inside {ST_PERM_ABS, ST_PERM_PAD, ST_PERM_SQZ});
    bus.out_valid_o      = (state_q == ST_SQUEEZE);
    bus.out_lane_idx_o   = sq_idx_q;
    bus.busy_o           = (state_q != ST_IDLE);
    bus.done_o           = done_q;
  end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keccak_sponge_ctrl
//   Scoreboard bench for keccak_sponge_ctrl. Each transaction pushes its
//   expected event sequence (clear, lane writes, pad, perm starts, squeeze
//   lanes, done) derived from the mode table and byte arithmetic; an
//   independent monitor pops and compares whenever the DUT shows an event.
//   A responder answers perm_start_o with a delayed perm_done_i.
// -----------------------------------------------------------------------------
module tb_keccak_sponge_ctrl;
  import keccak_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keccak_sponge_ctrl_if #(.RATE_W(RATE_WIDTH), .BA_W(BYTE_ABSORB_WIDTH)) bus ();

  keccak_sponge_ctrl #(
    .LANE_BYTES(8),
    .RATE_W    (RATE_WIDTH),
    .BA_W      (BYTE_ABSORB_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference mode table
  int ref_rate   [4] = '{1088, 576, 1344, 1088};
  int ref_digest [4] = '{4, 8, 0, 0};
  int ref_suffix [4] = '{'h06, 'h06, 'h1F, 'h1F};
  bit ref_xof    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  typedef enum int {EV_CLEAR, EV_WR, EV_PAD, EV_PERM, EV_OUT, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       a;
    int       b;
    int       c;
  } ev_t;

  ev_t exp_q[$];
  int  beats_q[$];
  int  tests       = 0;
  int  fails       = 0;
  bit  cur_xof     = 1'b0;
  bit  auto_perm   = 1'b1;
  bit  manual_done = 1'b0;
  bit  prev_perm   = 1'b0;
  int  perm_wait   = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void expect_ev(input ev_kind_e k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input ev_kind_e k, input int a, input int b, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got %s(%0d,%0d,%0d) expected none (t=%0t)",
               k.name(), a, b, c, $time);
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (k != e.kind) begin
        fails++;
        $display("FAIL event_order: got %s(%0d,%0d,%0d) expected %s(%0d,%0d,%0d) (t=%0t)",
                 k.name(), a, b, c, e.kind.name(), e.a, e.b, e.c, $time);
      end else begin
        case (k)
          EV_WR: begin
            check("lane_idx", 64'(a), 64'(e.a));
            check("lane_bytes", 64'(b), 64'(e.b));
          end
          EV_PAD: begin
            check("pad_rate", 64'(a), 64'(e.a));
            check("pad_suffix", 64'(b), 64'(e.b));
            check("pad_bytes_absorbed", 64'(c), 64'(e.c));
          end
          EV_OUT: check("out_lane_idx", 64'(a), 64'(e.a));
          default: ;
        endcase
      end
    end
  endtask

  // Monitor: samples late in the cycle, after inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (bus.clear_state_o) observe(EV_CLEAR, 0, 0, 0);
        if (bus.lane_wr_en_o)
          observe(EV_WR, int'(bus.lane_idx_o), int'(bus.lane_bytes_o), 0);
        if (bus.pad_en_o)
          observe(EV_PAD, int'(bus.rate_o), int'(bus.suffix_o), int'(bus.bytes_absorbed_o));
        if (bus.perm_start_o) begin
          check("perm_start_not_consecutive", 64'(prev_perm), 64'(0));
          observe(EV_PERM, 0, 0, 0);
        end
        if (bus.out_valid_o && bus.out_ready_i && !(bus.stop_i && cur_xof))
          observe(EV_OUT, int'(bus.out_lane_idx_o), 0, 0);
        if (bus.done_o) observe(EV_DONE, 0, 0, 0);
      end
      prev_perm = rst_n && bus.perm_start_o;
    end
  end

  // Permutation core stand-in: done 1..4 cycles after each start.
  initial begin
    bus.perm_done_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.perm_done_i = manual_done || (perm_wait == 0);
      if (perm_wait >= 0) perm_wait--;
      #3;
      if (auto_perm && rst_n && bus.perm_start_o) perm_wait = $urandom_range(0, 3);
    end
  end

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.in_ready_o, bus.clear_state_o, bus.lane_wr_en_o, bus.lane_idx_o,
                     bus.lane_bytes_o, bus.rate_o, bus.suffix_o, bus.bytes_absorbed_o,
                     bus.pad_en_o, bus.perm_start_o, bus.out_valid_o, bus.out_lane_idx_o,
                     bus.busy_o, bus.done_o}), 64'(0));
  endtask

  task automatic send_beat(input int bytes, input bit last, input bit blocked, input int gap);
    int budget = 100;
    bit fired  = 1'b0;
    bit first  = 1'b1;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid_i = 1'b0;
    end
    while (!fired && budget > 0) begin
      @(negedge clk);
      bus.in_valid_i = 1'b1;
      bus.in_last_i  = last;
      bus.in_bytes_i = 4'(bytes);
      #2;
      if (first && blocked) begin
        check("in_ready_low_in_perm_abs", 64'(bus.in_ready_o), 64'(0));
        check("no_lane_write_in_perm_abs", 64'(bus.lane_wr_en_o), 64'(0));
      end
      first  = 1'b0;
      fired  = bus.in_ready_o;
      budget--;
    end
    if (!fired) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got no acceptance expected acceptance within 100 cycles");
    end
  endtask

  // One complete hash; message beat sizes come from beats_q.
  task automatic run_txn(input int mode, input int n_sqz, input bit hold_out,
                         input bit poke_start, input int max_gap);
    int rb    = ref_rate[mode] / 8;
    int rl    = ref_rate[mode] / 64;
    int off   = 0;
    int n;
    int lanes;
    int fires = 0;
    int budget;
    bit blocked = 1'b0;
    bit held    = !hold_out;
    bit poked   = !poke_start;

    // Expected event sequence
    expect_ev(EV_CLEAR, 0, 0, 0);
    foreach (beats_q[i]) begin
      if (beats_q[i] > 0) expect_ev(EV_WR, off / 8, beats_q[i], 0);
      off += beats_q[i];
      if (off == rb) begin
        expect_ev(EV_PERM, 0, 0, 0);
        off = 0;
      end
    end
    expect_ev(EV_PAD, ref_rate[mode], ref_suffix[mode], off);
    expect_ev(EV_PERM, 0, 0, 0);
    n     = ref_xof[mode] ? n_sqz : ref_digest[mode];
    lanes = ref_xof[mode] ? rl : n;
    for (int k = 0; k < n; k++) begin
      expect_ev(EV_OUT, k % rl, 0, 0);
      if (ref_xof[mode] && (k % rl) == rl - 1) expect_ev(EV_PERM, 0, 0, 0);
    end
    expect_ev(EV_DONE, 0, 0, 0);
    cur_xof = ref_xof[mode];

    // Start
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.mode_i  = 2'(mode);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.mode_i  = 2'($urandom);

    // Absorb
    off = 0;
    foreach (beats_q[i]) begin
      bit last = (i == beats_q.size() - 1);
      send_beat(beats_q[i], last, blocked, blocked ? 0 : $urandom_range(0, max_gap));
      off += beats_q[i];
      blocked = (off == rb) && !last;
      if (off == rb) off = 0;
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;

    // Squeeze
    budget = 3000;
    while (fires < n && budget > 0) begin
      @(negedge clk);
      budget--;
      bus.start_i = 1'b0;
      if (!held && bus.out_valid_o) begin
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #2;
          check("out_valid_held", 64'(bus.out_valid_o), 64'(1));
          check("out_lane_idx_held", 64'(bus.out_lane_idx_o), 64'(fires % lanes));
          @(negedge clk);
        end
        held = 1'b1;
      end
      if (!poked && bus.out_valid_o) begin
        bus.start_i     = 1'b1;
        bus.mode_i      = 2'($urandom);
        bus.out_ready_i = 1'b0;
        #2;
        check("start_ignored_in_squeeze", 64'(bus.clear_state_o), 64'(0));
        poked = 1'b1;
        continue;
      end
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      #2;
      if (bus.out_valid_o && bus.out_ready_i) fires++;
    end
    if (fires < n) begin
      tests++; fails++;
      $display("FAIL squeeze_timeout: got %0d lanes expected %0d", fires, n);
    end
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.start_i     = 1'b0;

    if (cur_xof) begin
      budget = 50;
      while (!bus.out_valid_o && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("squeeze_ready_for_stop", 64'(bus.out_valid_o), 64'(1));
      bus.stop_i      = 1'b1;
      bus.out_ready_i = 1'($urandom_range(0, 1));  // stop must beat a concurrent fire
      @(negedge clk);
      bus.stop_i      = 1'b0;
      bus.out_ready_i = 1'b0;
    end

    budget = 50;
    while (bus.busy_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("returned_to_idle", 64'(bus.busy_o), 64'(0));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    bus.start_i     = 1'b0;
    bus.mode_i      = 2'd0;
    bus.stop_i      = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_last_i   = 1'b0;
    bus.in_bytes_i  = 4'd0;
    bus.out_ready_i = 1'b0;

    #12;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    // TC1: SHA3-256 empty message
    beats_q.delete(); beats_q.push_back(0);
    run_txn(0, 0, 1'b0, 1'b0, 0);

    // TC2: SHA3-256, exactly one block of 17 full lanes
    beats_q.delete();
    for (int i = 0; i < 17; i++) beats_q.push_back(8);
    run_txn(0, 0, 1'b0, 1'b0, 0);

    // TC3: SHA3-256, 16 full lanes + 7 bytes
    beats_q.delete();
    for (int i = 0; i < 16; i++) beats_q.push_back(8);
    beats_q.push_back(7);
    run_txn(0, 0, 1'b0, 1'b0, 1);

    // TC4: SHAKE128, 3 bytes, squeeze 25 lanes across a block boundary
    beats_q.delete(); beats_q.push_back(3);
    run_txn(2, 25, 1'b0, 1'b0, 0);

    // TC5: SHA3-512 with valid held through PERM_ABS, output stall, stray start
    beats_q.delete();
    for (int i = 0; i < 12; i++) beats_q.push_back(8);
    beats_q.push_back(4);
    run_txn(1, 0, 1'b1, 1'b1, 0);

    // TC6: reset during PERM_PAD
    auto_perm = 1'b0;
    expect_ev(EV_CLEAR, 0, 0, 0);
    expect_ev(EV_WR, 0, 5, 0);
    expect_ev(EV_PAD, 1088, 'h06, 5);
    expect_ev(EV_PERM, 0, 0, 0);
    cur_xof = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.mode_i  = 2'd0;
    @(negedge clk);
    bus.start_i = 1'b0;
    send_beat(5, 1'b1, 1'b0, 0);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reached_perm_pad", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("busy_in_perm_pad", 64'(bus.busy_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_run_reset_outputs");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    manual_done = 1'b1;
    @(posedge clk);
    #1;
    manual_done = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check_all_zero("stray_perm_done_ignored");
    auto_perm = 1'b1;
    beats_q.delete(); beats_q.push_back(0);
    run_txn(0, 0, 1'b0, 1'b0, 0);

    // Randomised transactions
    for (int t = 0; t < 25; t++) begin
      int mode  = $urandom_range(0, 3);
      int rl    = ref_rate[mode] / 64;
      int nfull = $urandom_range(0, 2 * rl + 1);
      beats_q.delete();
      for (int i = 0; i < nfull; i++) beats_q.push_back(8);
      beats_q.push_back($urandom_range(0, 8));
      run_txn(mode, $urandom_range(0, 2 * rl + 2), 1'b0, 1'b0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
